// File: rtl/fsqrt_seq.sv
// Sequential single-precision square root: Newton-Raphson refinement of 1/sqrt(x)
// seeded from an external table, with all arithmetic on shared fmul/fsub units.
module fsqrt_seq #(
    parameter int unsigned ITER = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y,
    output logic [31:0] init_x,
    input  logic [31:0] init_y,
    output logic        mul_req_valid,
    input  logic        mul_req_ready,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic        mul_resp_valid,
    input  logic [31:0] mul_resp,
    output logic        sub_req_valid,
    input  logic        sub_req_ready,
    output logic [31:0] sub_a,
    output logic [31:0] sub_b,
    input  logic        sub_resp_valid,
    input  logic [31:0] sub_resp
);
    localparam int unsigned W  = 32;
    localparam int unsigned EW = 8;
    localparam int unsigned CW = 2;
    localparam logic [W-1:0] QNAN      = 32'h7FC0_0000;
    localparam logic [W-1:0] POS_INF   = 32'h7F80_0000;
    localparam logic [W-1:0] THREE_HALF = 32'h3FC0_0000;

    typedef enum logic [2:0] {S_IDLE, S_BYPASS, S_INIT, S_ISSUE, S_WAIT, S_DONE} state_t;
    typedef enum logic [2:0] {OP_RR, OP_HT, OP_SUB, OP_RT, OP_XR} op_t;

    state_t        state_q, state_d;
    op_t           op_q, op_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  xr_q, xr_d, h_q, h_d, r_q, r_d, t_q, t_d, y_q, y_d;
    logic          in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic          mul_req_valid_q, mul_req_valid_d, sub_req_valid_q, sub_req_valid_d;
    logic [W-1:0]  mul_a_q, mul_a_d, mul_b_q, mul_b_d, sub_a_q, sub_a_d, sub_b_q, sub_b_d;
    logic [EW-1:0] x_exp, xr_exp;

    assign x_exp  = x[30:23];
    assign xr_exp = xr_q[30:23];

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        cnt_d           = cnt_q;
        xr_d            = xr_q;
        h_d             = h_q;
        r_d             = r_q;
        t_d             = t_q;
        y_d             = y_q;
        mul_a_d         = mul_a_q;
        mul_b_d         = mul_b_q;
        sub_a_d         = sub_a_q;
        sub_b_d         = sub_b_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    xr_d    = x;
                    state_d = S_BYPASS;
                    if (x_exp == EW'(0)) begin
                        y_d = {x[31], 31'b0};
                    end else if (x[31]) begin
                        y_d = QNAN;
                    end else if (x_exp == {EW{1'b1}}) begin
                        y_d = (x[22:0] != 23'b0) ? QNAN : POS_INF;
                    end else begin
                        state_d = S_INIT;
                    end
                end
            end
            S_BYPASS, S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_INIT: begin
                r_d     = init_y;
                h_d     = (xr_exp == EW'(1)) ? W'(0) : {xr_q[31], xr_exp - EW'(1), xr_q[22:0]};
                cnt_d   = CW'(0);
                op_d    = OP_RR;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if ((op_q == OP_SUB) ? sub_req_ready : mul_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (op_q == OP_SUB) begin
                    if (sub_resp_valid) begin
                        t_d     = sub_resp;
                        op_d    = OP_RT;
                        state_d = S_ISSUE;
                    end
                end else if (mul_resp_valid) begin
                    state_d = S_ISSUE;
                    case (op_q)
                        OP_RR: begin
                            t_d  = mul_resp;
                            op_d = OP_HT;
                        end
                        OP_HT: begin
                            t_d  = mul_resp;
                            op_d = OP_SUB;
                        end
                        OP_RT: begin
                            r_d   = mul_resp;
                            cnt_d = cnt_q + CW'(1);
                            op_d  = (cnt_q == CW'(ITER - 1)) ? OP_XR : OP_RR;
                        end
                        default: begin
                            y_d     = mul_resp;
                            state_d = S_DONE;
                        end
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Request channels are driven from the upcoming state so they line up with ISSUE
        in_ready_d      = (state_d == S_IDLE);
        out_valid_d     = (state_d == S_DONE) || (state_d == S_BYPASS);
        mul_req_valid_d = (state_d == S_ISSUE) && (op_d != OP_SUB);
        sub_req_valid_d = (state_d == S_ISSUE) && (op_d == OP_SUB);
        if (state_d == S_ISSUE) begin
            case (op_d)
                OP_RR: begin
                    mul_a_d = r_d;
                    mul_b_d = r_d;
                end
                OP_HT: begin
                    mul_a_d = h_d;
                    mul_b_d = t_d;
                end
                OP_SUB: begin
                    sub_a_d = THREE_HALF;
                    sub_b_d = t_d;
                end
                OP_RT: begin
                    mul_a_d = r_d;
                    mul_b_d = t_d;
                end
                default: begin
                    mul_a_d = xr_d;
                    mul_b_d = r_d;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            op_q            <= OP_RR;
            cnt_q           <= CW'(0);
            xr_q            <= W'(0);
            h_q             <= W'(0);
            r_q             <= W'(0);
            t_q             <= W'(0);
            y_q             <= W'(0);
            in_ready_q      <= 1'b1;
            out_valid_q     <= 1'b0;
            mul_req_valid_q <= 1'b0;
            sub_req_valid_q <= 1'b0;
            mul_a_q         <= W'(0);
            mul_b_q         <= W'(0);
            sub_a_q         <= W'(0);
            sub_b_q         <= W'(0);
        end else begin
            state_q         <= state_d;
            op_q            <= op_d;
            cnt_q           <= cnt_d;
            xr_q            <= xr_d;
            h_q             <= h_d;
            r_q             <= r_d;
            t_q             <= t_d;
            y_q             <= y_d;
            in_ready_q      <= in_ready_d;
            out_valid_q     <= out_valid_d;
            mul_req_valid_q <= mul_req_valid_d;
            sub_req_valid_q <= sub_req_valid_d;
            mul_a_q         <= mul_a_d;
            mul_b_q         <= mul_b_d;
            sub_a_q         <= sub_a_d;
            sub_b_q         <= sub_b_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign y             = y_q;
    assign init_x        = xr_q;
    assign mul_req_valid = mul_req_valid_q;
    assign mul_a         = mul_a_q;
    assign mul_b         = mul_b_q;
    assign sub_req_valid = sub_req_valid_q;
    assign sub_a         = sub_a_q;
    assign sub_b         = sub_b_q;

endmodule

// File: tb/tb_fsqrt_seq.sv
// Scoreboard bench for fsqrt_seq: real-arithmetic fmul/fsub/table models, a
// monitor that checks results against sqrt(x) and the handshake/timing rules.
module tb_fsqrt_seq;
    localparam int unsigned ITER = 2;
    localparam int LAT_IDEAL = 2 + 2 * (4 * int'(ITER) + 1);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] x = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] y;
    logic [31:0] init_x;
    logic [31:0] init_y;
    logic        mul_req_valid;
    logic        mul_req_ready = 1'b0;
    logic [31:0] mul_a, mul_b;
    logic        mul_resp_valid = 1'b0;
    logic [31:0] mul_resp = 32'h0;
    logic        sub_req_valid;
    logic        sub_req_ready = 1'b0;
    logic [31:0] sub_a, sub_b;
    logic        sub_resp_valid = 1'b0;
    logic [31:0] sub_resp = 32'h0;

    always #5 clk = ~clk;

    fsqrt_seq #(.ITER(ITER)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .x(x),
        .out_valid(out_valid), .out_ready(out_ready), .y(y),
        .init_x(init_x), .init_y(init_y),
        .mul_req_valid(mul_req_valid), .mul_req_ready(mul_req_ready),
        .mul_a(mul_a), .mul_b(mul_b),
        .mul_resp_valid(mul_resp_valid), .mul_resp(mul_resp),
        .sub_req_valid(sub_req_valid), .sub_req_ready(sub_req_ready),
        .sub_a(sub_a), .sub_b(sub_b),
        .sub_resp_valid(sub_resp_valid), .sub_resp(sub_resp)
    );

    typedef struct {
        logic [31:0] y;
        int          tol;
        int          t_in;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    bit   op_log[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;
    int   stall = 0;
    int   lat = 1;
    int   cur_tol = 1;
    int   cur_lat = -1;
    int   mcnt = 0;
    int   scnt = 0;
    int   ov_cycles = 0;
    int   in_hs_cycle = 0;
    int   out_hs_cycle = 0;
    bit   busy = 1'b0;
    logic prev_ov = 1'b0, prev_ordy = 1'b0;
    logic prev_mv = 1'b0, prev_mr = 1'b0, prev_sv = 1'b0, prev_sr = 1'b0;
    logic [31:0] prev_y, prev_ma, prev_mb, prev_sa, prev_sb;

    function automatic real s2r(input logic [31:0] b);
        logic [63:0] d;
        if (b[30:23] == 8'h0) return 0.0;
        d = {b[31], 11'(int'(b[30:23]) - 127 + 1023), b[22:0], 29'b0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2s(input real v);
        logic [63:0] d;
        logic [30:0] mag;
        logic [28:0] rem;
        int          e;
        d = $realtobits(v);
        e = int'(d[62:52]) - 1023 + 127;
        if (d[62:0] == 63'b0 || e <= 0) return {d[63], 31'b0};
        if (e >= 255) return {d[63], 8'hFF, 23'b0};
        mag = {8'(e), d[51:29]};
        rem = d[28:0];
        if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && mag[0])) mag = mag + 31'd1;
        return {d[63], mag};
    endfunction

    function automatic bit is_special(input logic [31:0] v);
        return (v[30:23] == 8'h0) || v[31] || (v[30:23] == 8'hFF);
    endfunction

    function automatic logic [31:0] ref_sqrt(input logic [31:0] v);
        if (v[30:23] == 8'h0) return {v[31], 31'b0};
        if (v[31]) return 32'h7FC0_0000;
        if (v[30:23] == 8'hFF) return (v[22:0] != 23'b0) ? 32'h7FC0_0000 : 32'h7F80_0000;
        return r2s($sqrt(s2r(v)));
    endfunction

    // Initial-approximation table: a correctly rounded 1/sqrt seed
    function automatic logic [31:0] rsqrt_table(input logic [31:0] v);
        if (is_special(v)) return 32'h0;
        return r2s(1.0 / $sqrt(s2r(v)));
    endfunction

    assign init_y = rsqrt_table(init_x);

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h at cycle %0d", name, got, want, cycle);
        end
    endtask

    task automatic check_ulp(input string name, input logic [31:0] got, input logic [31:0] want, input int tol);
        longint diff;
        checks++;
        diff = longint'(got[30:0]) - longint'(want[30:0]);
        if (diff < 0) diff = -diff;
        if (got[31] !== want[31] || $isunknown(got) || diff > longint'(tol)) begin
            errors++;
            $display("FAIL %s got %h expected %h (tol %0d ulp) at cycle %0d", name, got, want, tol, cycle);
        end
    endtask

    always @(posedge clk) cycle++;

    // Ready generators: hold ready low for 'stall' cycles of each request
    always @(posedge clk) begin
        #1;
        if (!mul_req_valid) begin
            mcnt = 0;
            mul_req_ready = (stall == 0);
        end else if (mcnt >= stall) begin
            mul_req_ready = 1'b1;
        end else begin
            mul_req_ready = 1'b0;
            mcnt++;
        end
    end

    always @(posedge clk) begin
        #1;
        if (!sub_req_valid) begin
            scnt = 0;
            sub_req_ready = (stall == 0);
        end else if (scnt >= stall) begin
            sub_req_ready = 1'b1;
        end else begin
            sub_req_ready = 1'b0;
            scnt++;
        end
    end

    // fmul model: response pulse 'lat' cycles after acceptance
    always begin : mul_unit
        logic [31:0] res;
        int          l;
        @(negedge clk);
        if (!rst && mul_req_valid && mul_req_ready) begin
            res = r2s(s2r(mul_a) * s2r(mul_b));
            op_log.push_back(1'b0);
            l = lat;
            @(posedge clk);
            repeat (l - 1) @(posedge clk);
            #1 mul_resp_valid = 1'b1;
            mul_resp = res;
            @(posedge clk);
            #1 mul_resp_valid = 1'b0;
        end
    end

    always begin : sub_unit
        logic [31:0] res;
        int          l;
        @(negedge clk);
        if (!rst && sub_req_valid && sub_req_ready) begin
            check("sub_a_const", 64'(sub_a), 64'h3FC0_0000);
            res = r2s(s2r(sub_a) - s2r(sub_b));
            op_log.push_back(1'b1);
            l = lat;
            @(posedge clk);
            repeat (l - 1) @(posedge clk);
            #1 sub_resp_valid = 1'b1;
            sub_resp = res;
            @(posedge clk);
            #1 sub_resp_valid = 1'b0;
        end
    end

    // Monitor and scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_q.delete();
            busy = 1'b0;
            prev_ov = 1'b0;
            prev_mv = 1'b0;
            prev_sv = 1'b0;
        end else begin
            check("in_ready", 64'(in_ready), 64'(!busy));
            if (out_valid) ov_cycles++;
            if (out_valid && !prev_ov) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", 64'(out_valid), 64'(0));
                end else if (exp_q[0].lat >= 0) begin
                    check("out_latency", 64'(cycle - exp_q[0].t_in), 64'(exp_q[0].lat));
                end
            end
            if (prev_ov && !prev_ordy) check("out_hold", {31'b0, out_valid, y}, {31'b0, 1'b1, prev_y});
            if (prev_mv && !prev_mr) check("mul_stall_hold", {mul_req_valid, mul_a, mul_b}, {1'b1, prev_ma, prev_mb});
            if (prev_sv && !prev_sr) check("sub_stall_hold", {sub_req_valid, sub_a, sub_b}, {1'b1, prev_sa, prev_sb});
            if (in_valid && in_ready) begin
                e.y    = ref_sqrt(x);
                e.tol  = is_special(x) ? 0 : cur_tol;
                e.t_in = cycle;
                e.lat  = is_special(x) ? 1 : cur_lat;
                exp_q.push_back(e);
                in_hs_cycle = cycle;
                busy = 1'b1;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_ulp("result_y", y, e.y, e.tol);
                end
                out_hs_cycle = cycle;
                busy = 1'b0;
            end
            prev_ov = out_valid;  prev_ordy = out_ready;  prev_y = y;
            prev_mv = mul_req_valid; prev_mr = mul_req_ready; prev_ma = mul_a; prev_mb = mul_b;
            prev_sv = sub_req_valid; prev_sr = sub_req_ready; prev_sa = sub_a; prev_sb = sub_b;
        end
    end

    task automatic send(input logic [31:0] xv, input int tol, input int latency);
        bit ok = 1'b0;
        cur_tol  = tol;
        cur_lat  = latency;
        in_valid = 1'b1;
        x        = xv;
        for (int i = 0; i < 5000; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("in_accept_timeout", 64'(ok), 64'(1));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_timeout", 64'(ok), 64'(1));
    endtask

    task automatic check_op_order(input string name);
        logic [31:0] got_pat = 32'h0, want_pat = 32'h0;
        for (int i = 0; i < op_log.size() && i < 32; i++) got_pat[i] = op_log[i];
        for (int i = 0; i < 4 * int'(ITER); i++) want_pat[i] = (i % 4 == 2);
        check(name, {32'(op_log.size()), got_pat}, {32'(4 * ITER + 1), want_pat});
    endtask

    logic [31:0] specials[6] = '{32'hC080_0000, 32'h8000_0000, 32'h7F80_0000,
                                 32'h7FC0_0001, 32'h0040_0000, 32'h0000_0000};

    initial begin
        int ov_before;
        bit seen;
        logic [31:0] rx;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_y", 64'(y), 64'(0));
        check("rst_init_x", 64'(init_x), 64'(0));
        check("rst_req_valid", {62'b0, mul_req_valid, sub_req_valid}, 64'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Nominal 4.0 with ideal units: latency, order and count of requests
        op_log.delete();
        send(32'h4080_0000, 1, LAT_IDEAL);
        wait_idle();
        check_op_order("op_order_4p0");

        // Specials: bypass at T+1, no arithmetic requests
        op_log.delete();
        foreach (specials[i]) begin
            send(specials[i], 0, 1);
            wait_idle();
        end
        check("bypass_no_requests", 64'(op_log.size()), 64'(0));

        // 1.0 with 5-cycle ready stalls and 3-cycle response latency
        stall = 5;
        lat   = 3;
        op_log.delete();
        send(32'h3F80_0000, 1, -1);
        wait_idle();
        check_op_order("op_order_stalled");
        stall = 0;
        lat   = 1;

        // Output back-pressure with a competing input held valid
        out_ready = 1'b0;
        send(32'h4180_0000, 1, LAT_IDEAL);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = out_valid;
        end
        check("backpressure_out_valid", 64'(seen), 64'(1));
        in_valid = 1'b1;
        x = 32'h4080_0000;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(32'h4080_0000, 1, LAT_IDEAL);
        check("accept_after_out_hs", 64'(in_hs_cycle - out_hs_cycle), 64'(1));
        wait_idle();

        // Reset while waiting on a slow fmul response; the late response must be ignored
        lat = 3;
        send(32'h4080_0000, 1, -1);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = mul_req_valid && mul_req_ready;
        end
        check("reset_test_req_seen", 64'(seen), 64'(1));
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        ov_before = ov_cycles;
        repeat (25) @(posedge clk);
        #1;
        check("no_out_after_reset", 64'(ov_cycles - ov_before), 64'(0));
        check("idle_after_reset", 64'(in_ready), 64'(1));
        lat = 1;
        send(32'h4110_0000, 1, LAT_IDEAL);
        wait_idle();

        // Randomised operands, stalls and latencies
        for (int n = 0; n < 40; n++) begin
            stall = int'($urandom_range(0, 2));
            lat   = int'($urandom_range(1, 3));
            if ($urandom_range(0, 5) == 0) begin
                rx = specials[$urandom_range(0, 5)];
            end else begin
                rx = {1'b0, 8'($urandom_range(20, 230)), 23'($urandom)};
            end
            send(rx, 4, (stall == 0 && lat == 1) ? LAT_IDEAL : -1);
            wait_idle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
